branch_redirect_ctrl: RTL and testbench

//  Sequences control-flow resolution for the 5-stage core. Consumes br_taken from the execute-stage

---
 rtl/branch_redirect_ctrl_if.sv | 29 ++
 rtl/branch_redirect_ctrl.sv | 149 ++++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/branch_redirect_ctrl_if.sv
// Execute-to-control resolve bus plus the redirect handshake toward fetch.
// master: execute stage / fetch side (drives resolve info, accepts redirects)
// slave : branch_redirect_ctrl (consumes resolve info, issues redirects)
interface branch_redirect_ctrl_if #(
    parameter int XLEN = 32
);
    logic            ex_valid;
    logic            ex_is_branch;
    logic            ex_is_jump;
    logic            ex_br_taken;
    logic            ex_pred_taken;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_target;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            redirect_ready;

    modport master (
        output ex_valid, ex_is_branch, ex_is_jump, ex_br_taken, ex_pred_taken,
        output ex_pc, ex_target, redirect_ready,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  ex_valid, ex_is_branch, ex_is_jump, ex_br_taken, ex_pred_taken,
        input  ex_pc, ex_target, redirect_ready,
        output redirect_valid, redirect_pc
    );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Control-flow resolution for the 5-stage core: 2-bit-counter BHT for fetch
// prediction, mispredict detection, pipeline flush and a held redirect request
// that stays up until fetch accepts it.
module branch_redirect_ctrl #(
    parameter int XLEN      = 32,
    parameter int BHT_IDX_W = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [XLEN-1:0]         if_pc,
    output logic                    if_pred_taken,
    branch_redirect_ctrl_if.slave   br_if,
    output logic                    flush_if_id,
    output logic                    flush_id_ex,
    output logic                    ex_stall,
    output logic [31:0]             br_count,
    output logic [31:0]             mispred_count
);

    localparam int BHT_ENTRIES = 2 ** BHT_IDX_W;

    typedef enum logic {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_redirect_valid;
    logic [XLEN-1:0]        r_redirect_pc;
    logic [31:0]            r_br_count;
    logic [31:0]            r_mispred_count;
    logic [1:0]             r_bht [BHT_ENTRIES];

    logic                   w_resolve;
    logic                   w_actual;
    logic                   w_mispred;
    logic [XLEN-1:0]        w_correct_pc;
    logic                   w_latch_redirect;
    logic                   w_bht_we;
    logic [BHT_IDX_W-1:0]   w_if_idx;
    logic [BHT_IDX_W-1:0]   w_ex_idx;

    // Word-aligned PCs: drop the two byte-offset bits when indexing the BHT.
    assign w_if_idx = if_pc[BHT_IDX_W+1:2];
    assign w_ex_idx = br_if.ex_pc[BHT_IDX_W+1:2];

    // Read port sees the pre-edge value, so a same-cycle update is not forwarded.
    assign if_pred_taken = r_bht[w_if_idx][1];

    // Resolution only while IDLE; anything arriving during a redirect is a squashed instruction.
    assign w_resolve    = br_if.ex_valid & (br_if.ex_is_branch | br_if.ex_is_jump) & (r_state == IDLE);
    assign w_actual     = br_if.ex_is_jump ? 1'b1 : br_if.ex_br_taken;
    assign w_mispred    = w_resolve & (w_actual != br_if.ex_pred_taken);
    assign w_correct_pc = w_actual ? br_if.ex_target
                                   : br_if.ex_pc + {{(XLEN-3){1'b0}}, 3'b100};
    // A op flagged as both branch and jump is treated as a jump and never trains the BHT.
    assign w_bht_we     = w_resolve & br_if.ex_is_branch & ~br_if.ex_is_jump;

    assign br_if.redirect_valid = r_redirect_valid;
    assign br_if.redirect_pc    = r_redirect_pc;
    assign br_count             = r_br_count;
    assign mispred_count        = r_mispred_count;

    // State register for the redirect sequencer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and flush/stall decode; flushes fire in the mispredict cycle itself.
    always_comb begin
        w_state_nxt      = r_state;
        flush_if_id      = 1'b0;
        flush_id_ex      = 1'b0;
        ex_stall         = 1'b0;
        w_latch_redirect = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_mispred) begin
                    flush_if_id      = 1'b1;
                    flush_id_ex      = 1'b1;
                    w_latch_redirect = 1'b1;
                    w_state_nxt      = REDIRECT;
                end
            end
            REDIRECT: begin
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
                ex_stall    = 1'b1;
                if (br_if.redirect_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Redirect request: captured on mispredict, held stable until fetch accepts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else if (w_latch_redirect) begin
            r_redirect_valid <= 1'b1;
            r_redirect_pc    <= w_correct_pc;
        end else if ((r_state == REDIRECT) && br_if.redirect_ready) begin
            r_redirect_valid <= 1'b0;
        end
    end

    // Free-running statistics, wrapping at 2**32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_br_count      <= '0;
            r_mispred_count <= '0;
        end else begin
            if (w_resolve) begin
                r_br_count <= r_br_count + 32'd1;
            end
            if (w_mispred) begin
                r_mispred_count <= r_mispred_count + 32'd1;
            end
        end
    end

    // BHT training: saturating 2-bit counters, reset to weakly not-taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (w_bht_we) begin
            if (w_actual) begin
                if (r_bht[w_ex_idx] != 2'b11) begin
                    r_bht[w_ex_idx] <= r_bht[w_ex_idx] + 2'd1;
                end
            end else begin
                if (r_bht[w_ex_idx] != 2'b00) begin
                    r_bht[w_ex_idx] <= r_bht[w_ex_idx] - 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: a reference BHT/counter model predicts each
// resolve; expected redirect PCs are queued at resolve time and popped when
// fetch accepts the redirect.
module tb_branch_redirect_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        ex_stall;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    branch_redirect_ctrl_if #(.XLEN(32)) bi ();

    branch_redirect_ctrl #(.XLEN(32), .BHT_IDX_W(6)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_pc         (if_pc),
        .if_pred_taken (if_pred_taken),
        .br_if         (bi),
        .flush_if_id   (flush_if_id),
        .flush_id_ex   (flush_id_ex),
        .ex_stall      (ex_stall),
        .br_count      (br_count),
        .mispred_count (mispred_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk;
    int          n_fail;
    logic [1:0]  m_bht [64];
    logic [31:0] m_br;
    logic [31:0] m_mis;
    logic [31:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
        m_br  = 0;
        m_mis = 0;
        exp_q.delete();
    endtask

    task automatic idle_inputs();
        bi.ex_valid       = 1'b0;
        bi.ex_is_branch   = 1'b0;
        bi.ex_is_jump     = 1'b0;
        bi.ex_br_taken    = 1'b0;
        bi.ex_pred_taken  = 1'b0;
        bi.ex_pc          = '0;
        bi.ex_target      = '0;
        bi.redirect_ready = 1'b0;
    endtask

    task automatic pred_chk(input string tag, input logic [31:0] pc, input logic exp);
        if_pc = pc;
        #1;
        chk(tag, {31'd0, if_pred_taken}, {31'd0, exp});
    endtask

    // Drive one resolving instruction for one cycle (called at posedge+1).
    task automatic resolve(input logic [31:0] pc, input logic [31:0] tgt, input bit is_br,
                           input bit is_j, input bit taken, input bit pred, output bit mis);
        logic        actual;
        logic [31:0] cpc;
        actual = is_j ? 1'b1 : taken;
        mis    = (actual != pred);
        cpc    = actual ? tgt : pc + 32'd4;
        bi.ex_valid      = 1'b1;
        bi.ex_is_branch  = is_br;
        bi.ex_is_jump    = is_j;
        bi.ex_br_taken   = taken;
        bi.ex_pred_taken = pred;
        bi.ex_pc         = pc;
        bi.ex_target     = tgt;
        if_pc            = pc;
        @(negedge clk);
        chk("flush_if_id_N", {31'd0, flush_if_id}, {31'd0, mis});
        chk("flush_id_ex_N", {31'd0, flush_id_ex}, {31'd0, mis});
        chk("ex_stall_N", {31'd0, ex_stall}, 32'd0);
        chk("rv_N", {31'd0, bi.redirect_valid}, 32'd0);
        chk("bht_read_old", {31'd0, if_pred_taken}, {31'd0, m_bht[pc[7:2]][1]});
        m_br = m_br + 1;
        if (mis) begin
            m_mis = m_mis + 1;
            exp_q.push_back(cpc);
        end
        if (is_br && !is_j) begin
            if (actual && m_bht[pc[7:2]] != 2'b11) m_bht[pc[7:2]] = m_bht[pc[7:2]] + 2'd1;
            if (!actual && m_bht[pc[7:2]] != 2'b00) m_bht[pc[7:2]] = m_bht[pc[7:2]] - 2'd1;
        end
        @(posedge clk);
        #1;
        idle_inputs();
        chk("br_count", br_count, m_br);
        chk("mispred_count", mispred_count, m_mis);
    endtask

    // Hold ready low for 'delay' cycles (with ignored ex_valid pulses), then accept.
    task automatic handshake(input int delay);
        for (int i = 0; i < delay; i++) begin
            bi.redirect_ready = 1'b0;
            bi.ex_valid       = 1'b1;
            bi.ex_is_branch   = 1'b1;
            bi.ex_br_taken    = 1'b1;
            bi.ex_pred_taken  = 1'b0;
            bi.ex_pc          = 32'h0000_0508;
            bi.ex_target      = 32'h0000_0900;
            @(negedge clk);
            chk("rv_held", {31'd0, bi.redirect_valid}, 32'd1);
            if (exp_q.size() != 0) chk("rpc_held", bi.redirect_pc, exp_q[0]);
            chk("flush_held", {30'd0, flush_if_id, flush_id_ex}, 32'd3);
            chk("stall_held", {31'd0, ex_stall}, 32'd1);
            @(posedge clk);
            #1;
        end
        idle_inputs();
        bi.redirect_ready = 1'b1;
        @(negedge clk);
        chk("rv_accept", {31'd0, bi.redirect_valid}, 32'd1);
        if (exp_q.size() == 0) chk("sb_nonempty", 32'd0, 32'd1);
        else chk("redirect_pc", bi.redirect_pc, exp_q.pop_front());
        @(posedge clk);
        #1;
        bi.redirect_ready = 1'b0;
        chk("rv_after", {31'd0, bi.redirect_valid}, 32'd0);
        @(negedge clk);
        chk("flush_after", {30'd0, flush_if_id, flush_id_ex}, 32'd0);
        chk("stall_after", {31'd0, ex_stall}, 32'd0);
        chk("br_count_after", br_count, m_br);
        chk("mis_count_after", mispred_count, m_mis);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit mis;
        n_chk  = 0;
        n_fail = 0;
        model_reset();
        idle_inputs();
        if_pc = 32'h0000_0100;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_pred", {31'd0, if_pred_taken}, 32'd0);
        chk("rst_rv", {31'd0, bi.redirect_valid}, 32'd0);
        chk("rst_rpc", bi.redirect_pc, 32'd0);
        chk("rst_flush", {29'd0, flush_if_id, flush_id_ex, ex_stall}, 32'd0);
        chk("rst_br_count", br_count, 32'd0);
        chk("rst_mis_count", mispred_count, 32'd0);
        @(posedge clk);
        #1;

        // redirect_ready while IDLE has no effect
        bi.redirect_ready = 1'b1;
        @(posedge clk);
        #1;
        bi.redirect_ready = 1'b0;
        chk("idle_ready_rv", {31'd0, bi.redirect_valid}, 32'd0);

        // Taken BEQ mispredicted as NT, accepted immediately
        resolve(32'h0000_0200, 32'h0000_0180, 1, 0, 1, 0, mis);
        handshake(0);
        pred_chk("bht_0x200", 32'h0000_0200, 1'b1);

        // NT BNE mispredicted as taken, ready held low 3 cycles
        resolve(32'h0000_0300, 32'h0000_0700, 1, 0, 0, 1, mis);
        handshake(3);

        // JALR from the top of memory, then NT branch whose fall-through wraps to 0
        resolve(32'hFFFF_FFFC, 32'h0000_0040, 0, 1, 0, 0, mis);
        handshake(0);
        pred_chk("bht_jalr_untouched", 32'hFFFF_FFFC, m_bht[63][1]);
        resolve(32'hFFFF_FFFC, 32'h0000_1000, 1, 0, 0, 1, mis);
        handshake(1);

        // Both is_branch and is_jump: treated as jump, correctly predicted, no BHT change
        resolve(32'h0000_0408, 32'h0000_0800, 1, 1, 0, 1, mis);
        chk("both_no_mis", {31'd0, mis}, 32'd0);
        pred_chk("bht_both_untouched", 32'h0000_0408, 1'b0);

        // Training to saturation then one NT outcome
        for (int k = 0; k < 4; k++) begin
            resolve(32'h0000_0404, 32'h0000_0600, 1, 0, 1, m_bht[1][1], mis);
            if (mis) handshake(0);
        end
        chk("bht_sat", {30'd0, m_bht[1]}, 32'd3);
        pred_chk("bht_sat_pred", 32'h0000_0404, 1'b1);
        resolve(32'h0000_0404, 32'h0000_0600, 1, 0, 0, m_bht[1][1], mis);
        if (mis) handshake(0);
        pred_chk("bht_after_nt", 32'h0000_0404, 1'b1);
        pred_chk("bht_ignored_pulse", 32'h0000_0508, 1'b0);

        // Reset asserted while a redirect is pending
        resolve(32'h0000_010C, 32'h0000_0800, 1, 0, 1, 0, mis);
        @(negedge clk);
        chk("pre_rst_rv", {31'd0, bi.redirect_valid}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_rv", {31'd0, bi.redirect_valid}, 32'd0);
        chk("async_rst_flush", {29'd0, flush_if_id, flush_id_ex, ex_stall}, 32'd0);
        chk("async_rst_count", br_count, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pred_chk("rst_bht_idx3", 32'h0000_010C, 1'b0);
        resolve(32'hFFFF_FFFC, 32'h0000_0020, 1, 0, 1, 0, mis);
        handshake(0);
        pred_chk("rst_bht_reinit", 32'hFFFF_FFFC, 1'b1);

        chk("sb_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
